// File: rtl/bp_pkg.sv
// Shared types and constants for the fetch-stage branch predictor:
// 2-bit counter encodings, default geometry and the table entry layout.
package bp_pkg;

    // Default number of index bits (table depth is 2**IDX_W)
    localparam int IDX_W_DEF = 4;

    // Widest possible tag (pc[31:2]); narrower tags are stored zero-extended
    // so one entry type serves every IDX_W.
    localparam int TAG_MAX_W = 30;

    // 2-bit saturating counter states
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam logic [1:0] CTR_RESET = WNT;
    localparam logic [1:0] CTR_ALLOC = WT;

    // One branch target buffer entry
    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [31:0]          target;
        logic [1:0]           ctr;
        logic                 is_jump;
    } bp_entry_t;

    // Tag of a PC for a table indexed by pc[idx_w+1:2]
    function automatic logic [TAG_MAX_W-1:0] pc_tag(input logic [31:0] pc, input int idx_w);
        logic [31:0] shifted;
        shifted = pc >> (idx_w + 2);
        return shifted[TAG_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// Next-state function of a 2-bit saturating direction counter.
module bp_sat_ctr
    import bp_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] ctr_next_o
);

    // Step towards strongly-taken or strongly-not-taken, holding at the ends
    always_comb begin
        ctr_next_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != ST) begin
                ctr_next_o = ctr_i + 2'd1;
            end
        end else begin
            if (ctr_i != SNT) begin
                ctr_next_o = ctr_i - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry 2-bit counters. Predicts the next fetch
// PC combinationally, trains from EX resolutions, raises the front-end
// redirect on a misprediction and keeps saturating performance counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_is_branch,
    input  logic        ex_is_jump,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);

    localparam int DEPTH = 1 << IDX_W;

    // Table kept in flops so it can be fully reset and read asynchronously
    bp_entry_t entry_q [DEPTH];

    logic [31:0] branch_cnt_q;
    logic [31:0] mispred_cnt_q;

    // ---------------- Lookup ----------------
    logic [IDX_W-1:0] if_idx;
    bp_entry_t        if_ent;
    logic             if_hit;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_ent = entry_q[if_idx];
    assign if_hit = if_ent.valid && (if_ent.tag == pc_tag(if_pc, IDX_W));

    // Jumps always redirect on a hit; branches follow the counter MSB
    always_comb begin
        pred_taken  = if_hit && (if_ent.is_jump || if_ent.ctr[1]);
        pred_target = pred_taken ? if_ent.target : (if_pc + 32'd4);
    end

    // ---------------- Resolution ----------------
    // A wrong direction, or a right "taken" with a wrong target, both flush
    always_comb begin
        mispredict  = ex_valid &&
                      ((ex_taken != ex_pred_taken) ||
                       (ex_taken && (ex_target != ex_pred_target)));
        redirect_pc = (ex_valid && ex_taken) ? ex_target : (ex_pc + 32'd4);
    end

    // ---------------- Update ----------------
    logic [IDX_W-1:0] ex_idx;
    bp_entry_t        ex_ent;
    logic             ex_hit;
    logic             ex_trains;
    logic [1:0]       ctr_next;
    bp_entry_t        entry_d;
    logic             entry_we;

    assign ex_idx    = ex_pc[IDX_W+1:2];
    assign ex_ent    = entry_q[ex_idx];
    assign ex_hit    = ex_ent.valid && (ex_ent.tag == pc_tag(ex_pc, IDX_W));
    // Only control transfers touch the table; a set jump flag wins over branch
    assign ex_trains = ex_valid && (ex_is_branch || ex_is_jump);

    bp_sat_ctr u_sat_ctr (
        .ctr_i      (ex_ent.ctr),
        .taken_i    (ex_taken),
        .ctr_next_o (ctr_next)
    );

    // Build the replacement entry: train on a hit, allocate on a taken miss
    always_comb begin
        entry_d  = ex_ent;
        entry_we = 1'b0;
        if (ex_trains) begin
            if (ex_hit) begin
                entry_we        = 1'b1;
                entry_d.ctr     = ctr_next;
                entry_d.is_jump = ex_is_jump;
                if (ex_taken) begin
                    entry_d.target = ex_target;
                end
            end else if (ex_taken) begin
                entry_we        = 1'b1;
                entry_d.valid   = 1'b1;
                entry_d.tag     = pc_tag(ex_pc, IDX_W);
                entry_d.target  = ex_target;
                entry_d.ctr     = CTR_ALLOC;
                entry_d.is_jump = ex_is_jump;
            end
        end
    end

    // Table write; reset clears every entry and blocks a concurrent update
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i].valid   <= 1'b0;
                entry_q[i].tag     <= '0;
                entry_q[i].target  <= '0;
                entry_q[i].ctr     <= CTR_RESET;
                entry_q[i].is_jump <= 1'b0;
            end
        end else if (entry_we) begin
            entry_q[ex_idx] <= entry_d;
        end
    end

    // ---------------- Performance counters ----------------
    logic [31:0] branch_cnt_d;
    logic [31:0] mispred_cnt_d;

    // Saturating increments so the counters never wrap back to zero
    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (ex_valid && (branch_cnt_q != 32'hFFFF_FFFF)) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
        end
        if (mispredict && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
            mispred_cnt_d = mispred_cnt_q + 32'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios with literal
// expectations, then randomized traffic against a behavioural table model.
module tb_branch_predictor;

    localparam int IW = 4;
    localparam int N  = 1 << IW;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_is_branch;
    logic        ex_is_jump;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_predictor #(.IDX_W(IW)) dut (
        .clk            (clk),
        .reset          (reset),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_is_branch   (ex_is_branch),
        .ex_is_jump     (ex_is_jump),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc),
        .branch_cnt     (branch_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    // ---------------- Behavioural model ----------------
    bit          m_valid  [N];
    logic [31:0] m_tag    [N];
    logic [31:0] m_target [N];
    int          m_ctr    [N];
    bit          m_jump   [N];
    logic [31:0] m_bcnt;
    logic [31:0] m_mcnt;
    bit          model_ok = 1'b0;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        int i;
        i = idx_of(pc);
        return m_valid[i] && (m_tag[i] == (pc >> (IW + 2))) && (m_jump[i] || m_ctr[i] >= 2);
    endfunction

    function automatic logic [31:0] m_pred_tgt(input logic [31:0] pc);
        return m_pred(pc) ? m_target[idx_of(pc)] : pc + 32'd4;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every cycle, then advance the model for the coming clock edge
    always @(negedge clk) begin
        bit          exp_mp;
        logic [31:0] exp_rd;
        int          i;
        bit          hit;
        exp_mp = ex_valid && ((ex_taken != ex_pred_taken) || (ex_taken && ex_target != ex_pred_target));
        exp_rd = (ex_valid && ex_taken) ? ex_target : ex_pc + 32'd4;
        if (model_ok) begin
            check("pred_taken",  {31'd0, pred_taken}, {31'd0, m_pred(if_pc)});
            check("pred_target", pred_target, m_pred_tgt(if_pc));
            check("mispredict",  {31'd0, mispredict}, {31'd0, exp_mp});
            check("redirect_pc", redirect_pc, exp_rd);
            check("branch_cnt",  branch_cnt, m_bcnt);
            check("mispred_cnt", mispred_cnt, m_mcnt);
        end
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                m_valid[k]  = 1'b0;
                m_tag[k]    = '0;
                m_target[k] = '0;
                m_ctr[k]    = 1;
                m_jump[k]   = 1'b0;
            end
            m_bcnt   = '0;
            m_mcnt   = '0;
            model_ok = 1'b1;
        end else if (model_ok && ex_valid) begin
            if (m_bcnt != 32'hFFFF_FFFF) m_bcnt = m_bcnt + 32'd1;
            if (exp_mp && m_mcnt != 32'hFFFF_FFFF) m_mcnt = m_mcnt + 32'd1;
            if (ex_is_branch || ex_is_jump) begin
                i   = idx_of(ex_pc);
                hit = m_valid[i] && (m_tag[i] == (ex_pc >> (IW + 2)));
                if (hit) begin
                    if (ex_taken) m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                    else          m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
                    if (ex_taken) m_target[i] = ex_target;
                    m_jump[i] = ex_is_jump;
                end else if (ex_taken) begin
                    m_valid[i]  = 1'b1;
                    m_tag[i]    = ex_pc >> (IW + 2);
                    m_target[i] = ex_target;
                    m_ctr[i]    = 2;
                    m_jump[i]   = ex_is_jump;
                end
            end
        end
    end

    // ---------------- Stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_set(input bit v, input logic [31:0] pc, input bit br, input bit jp,
                          input bit tk, input logic [31:0] tgt, input bit pt, input logic [31:0] ptgt);
        ex_valid       = v;
        ex_pc          = pc;
        ex_is_branch   = br;
        ex_is_jump     = jp;
        ex_taken       = tk;
        ex_target      = tgt;
        ex_pred_taken  = pt;
        ex_pred_target = ptgt;
    endtask

    task automatic idle();
        ex_set(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    function automatic logic [31:0] rand_pc();
        return 32'h1000 | (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
    endfunction

    // ---------------- Directed then random stimulus ----------------
    initial begin
        logic [31:0] pc;
        logic [31:0] tgt;
        int          fl;
        bit          tk;

        reset = 1'b1;
        if_pc = 32'h100;
        idle();
        repeat (2) cyc();
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_pred_taken",  {31'd0, pred_taken}, 32'd0);
        check("rst_pred_target", pred_target, 32'h104);
        check("rst_branch_cnt",  branch_cnt, 32'd0);
        check("rst_mispred_cnt", mispred_cnt, 32'd0);
        if_pc = 32'hFFFF_FFFC;
        #1 check("wrap_pred_target", pred_target, 32'h0);
        if_pc = 32'h100;
        cyc();

        // First taken beq allocates
        ex_set(1, 32'h100, 1, 0, 1, 32'h80, 0, 32'h104);
        @(negedge clk);
        check("beq_mispredict", {31'd0, mispredict}, 32'd1);
        check("beq_redirect",   redirect_pc, 32'h80);
        cyc(); idle();
        @(negedge clk);
        check("alloc_pred_taken",  {31'd0, pred_taken}, 32'd1);
        check("alloc_pred_target", pred_target, 32'h80);
        check("alloc_branch_cnt",  branch_cnt, 32'd1);
        check("alloc_mispred_cnt", mispred_cnt, 32'd1);
        cyc();

        // Not taken twice: 10 -> 01 -> 00
        ex_set(1, 32'h100, 1, 0, 0, 32'h0, 1, 32'h80);
        @(negedge clk);
        check("nt1_mispredict", {31'd0, mispredict}, 32'd1);
        check("nt1_redirect",   redirect_pc, 32'h104);
        cyc();
        ex_set(1, 32'h100, 1, 0, 0, 32'h0, 0, 32'h104);
        @(negedge clk);
        check("nt2_mispredict", {31'd0, mispredict}, 32'd0);
        cyc(); idle();
        @(negedge clk);
        check("nt_pred_taken",  {31'd0, pred_taken}, 32'd0);
        check("nt_pred_target", pred_target, 32'h104);
        cyc();

        // Four taken saturate at 11; one not-taken keeps predicting taken
        repeat (4) begin
            ex_set(1, 32'h100, 1, 0, 1, 32'h80, 0, 32'h104);
            cyc();
        end
        ex_set(1, 32'h100, 1, 0, 0, 32'h0, 1, 32'h80);
        cyc(); idle();
        @(negedge clk);
        check("sat_pred_taken", {31'd0, pred_taken}, 32'd1);
        cyc();
        ex_set(1, 32'h100, 1, 0, 0, 32'h0, 1, 32'h80);
        cyc(); idle();
        @(negedge clk);
        check("sat2_pred_taken", {31'd0, pred_taken}, 32'd0);
        cyc();

        // jal allocation and aliasing eviction
        ex_set(1, 32'h200, 0, 1, 1, 32'h400, 0, 32'h204);
        cyc(); idle();
        if_pc = 32'h200;
        @(negedge clk);
        check("jal_pred_taken",  {31'd0, pred_taken}, 32'd1);
        check("jal_pred_target", pred_target, 32'h400);
        if_pc = 32'h240;
        #1;
        check("alias_pred_taken",  {31'd0, pred_taken}, 32'd0);
        check("alias_pred_target", pred_target, 32'h244);
        cyc();
        ex_set(1, 32'h240, 1, 0, 1, 32'h300, 0, 32'h244);
        cyc(); idle();
        if_pc = 32'h200;
        @(negedge clk);
        check("evicted_pred_taken", {31'd0, pred_taken}, 32'd0);
        if_pc = 32'h240;
        #1;
        check("evictor_pred_taken",  {31'd0, pred_taken}, 32'd1);
        check("evictor_pred_target", pred_target, 32'h300);
        cyc();

        // Reset wins over a concurrent resolution
        reset = 1'b1;
        ex_set(1, 32'h500, 1, 0, 1, 32'h600, 0, 32'h504);
        cyc();
        reset = 1'b0;
        idle();
        if_pc = 32'h500;
        @(negedge clk);
        check("rstwin_pred_taken", {31'd0, pred_taken}, 32'd0);
        check("rstwin_branch_cnt", branch_cnt, 32'd0);
        check("rstwin_mispred_cnt", mispred_cnt, 32'd0);
        cyc();

        // Randomized traffic; the negedge process compares against the model
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            if_pc = rand_pc();
            pc    = rand_pc();
            tgt   = rand_pc();
            fl    = int'($urandom_range(0, 3));
            tk    = (fl >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
            ex_set(($urandom_range(0, 3) != 0), pc, fl[0], fl[1], tk, tgt, 1'b0, 32'h0);
            if ($urandom_range(0, 1) == 1) begin
                ex_pred_taken  = m_pred(pc);
                ex_pred_target = m_pred_tgt(pc);
            end else begin
                ex_pred_taken  = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 2))
                    0:       ex_pred_target = pc + 32'd4;
                    1:       ex_pred_target = tgt;
                    default: ex_pred_target = rand_pc();
                endcase
            end
            cyc();
        end
        reset = 1'b0;
        idle();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
